// File: rtl/cordic_pkg.sv
// Shared region and op codes for the CORDIC back-end blocks.
package cordic_pkg;
    localparam logic [1:0] REGION_NONE    = 2'b00;
    localparam logic [1:0] REGION_NEG_COS = 2'b01;
    localparam logic [1:0] REGION_NEG_SIN = 2'b10;
    localparam logic [1:0] REGION_NONE2   = 2'b11;

    localparam logic [1:0] OP_COS  = 2'b00;
    localparam logic [1:0] OP_SIN  = 2'b01;
    localparam logic [1:0] OP_BOTH = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;
endpackage

// File: rtl/sign_fix_lane.sv
// Combinational IEEE-754 sign flip for one lane; magnitude bits pass untouched.
// SIGN_FIX_ZERO_CLEAN_EN forces a zero-magnitude result to +0.
module sign_fix_lane #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic         negate,
    output logic [W-1:0] data_out
);
    logic sign;

    always_comb begin
        sign = data[W-1] ^ negate;
`ifdef SIGN_FIX_ZERO_CLEAN_EN
        if (data[W-2:0] == '0) sign = 1'b0;
`endif
        data_out = {sign, data[W-2:0]};
    end
endmodule

// File: rtl/cordic_sign_fix_pipe.sv
// Quadrant sign correction of CORDIC sin/cos into a DEPTH-entry output FIFO with valid/ready.
// Outputs are registered; optional SIGN_FIX_ZERO_CLEAN_EN suppresses -0 results.
module cordic_sign_fix_pipe
    import cordic_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [1:0]   in_region,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_cos,
    output logic [W-1:0] out_sin,
    output logic [1:0]   out_op,
    output logic         err_op
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  cos_mem [DEPTH];
    logic [W-1:0]  sin_mem [DEPTH];
    logic [1:0]    op_mem  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop;
    logic [W-1:0]  cos_fixed, sin_fixed, wr_cos, wr_sin;
    logic [W-1:0]  head_cos, head_sin;
    logic [1:0]    head_op;

    sign_fix_lane #(.W(W)) u_cos_lane (
        .data     (in_x),
        .negate   (in_region == REGION_NEG_COS),
        .data_out (cos_fixed)
    );

    sign_fix_lane #(.W(W)) u_sin_lane (
        .data     (in_y),
        .negate   (in_region == REGION_NEG_SIN),
        .data_out (sin_fixed)
    );

    // An illegal op bypasses correction entirely so the raw CORDIC result is visible for debug.
    always_comb begin
        wr_cos = cos_fixed;
        wr_sin = sin_fixed;
        case (in_op)
            OP_COS:  wr_sin = '0;
            OP_SIN:  wr_cos = '0;
            OP_ILL: begin
                wr_cos = in_x;
                wr_sin = in_y;
            end
            default: ;
        endcase
    end

    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign wr_ptr_nxt = wr_ptr + AW'(push);
    assign rd_ptr_nxt = rd_ptr + AW'(pop);
    assign count_nxt  = count + CW'(push) - CW'(pop);

    // Next head comes straight from the write port when the incoming beat lands in the head slot.
    always_comb begin
        head_cos = cos_mem[rd_ptr_nxt];
        head_sin = sin_mem[rd_ptr_nxt];
        head_op  = op_mem[rd_ptr_nxt];
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_cos = wr_cos;
            head_sin = wr_sin;
            head_op  = in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cos_mem[wr_ptr] <= wr_cos;
            sin_mem[wr_ptr] <= wr_sin;
            op_mem[wr_ptr]  <= in_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_cos   <= '0;
            out_sin   <= '0;
            out_op    <= '0;
            err_op    <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= (count_nxt != CW'(DEPTH));
            out_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                out_cos <= head_cos;
                out_sin <= head_sin;
                out_op  <= head_op;
            end
            if (push && (in_op == OP_ILL)) err_op <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cordic_sign_fix_pipe.sv
// Scoreboard bench for cordic_sign_fix_pipe: directed cases plus randomized traffic with random backpressure.
module tb_cordic_sign_fix_pipe;
    import cordic_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0, in_y = '0;
    logic [1:0]  in_region = '0, in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_cos, out_sin;
    logic [1:0]  out_op;
    logic        err_op;
    logic        rand_done;

    typedef struct packed {
        logic [31:0] c;
        logic [31:0] s;
        logic [1:0]  op;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cordic_sign_fix_pipe #(.W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_region (in_region),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .out_op    (out_op),
        .err_op    (err_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Reference: flip bit 31 when asked, optionally scrub -0.
    function automatic logic [31:0] fix(input logic [31:0] v, input bit neg);
        logic [31:0] r;
        r = neg ? (v ^ 32'h8000_0000) : v;
`ifdef SIGN_FIX_ZERO_CLEAN_EN
        if (r[30:0] == 31'd0) r = 32'd0;
`endif
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [1:0] rg, input logic [1:0] op);
        exp_t e;
        e.op = op;
        if (op == 2'd3) begin
            e.c = x;
            e.s = y;
        end else begin
            e.c = (op == 2'd1) ? 32'd0 : fix(x, rg == 2'd1);
            e.s = (op == 2'd0) ? 32'd0 : fix(y, rg == 2'd2);
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h/%h expected no beat", out_cos, out_sin);
            end else begin
                e = sbq.pop_front();
                check("out_cos", out_cos, e.c);
                check("out_sin", out_sin, e.s);
                check("out_op", 32'(out_op), 32'(e.op));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] rg, input logic [1:0] op);
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_region = rg;
        in_op     = op;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                sbq.push_back(model(x, y, rg, op));
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        timeout_fail("send_timeout");
    endtask

    task automatic set_out_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    task automatic drain;
        set_out_ready(1'b1);
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) timeout_fail("drain");
        check("empty_after_drain", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_cos", out_cos, 32'd0);
        check("rst_out_sin", out_sin, 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        check("rst_err_op", 32'(err_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Dual op, negate cos; result visible one edge after accept.
        send(32'h3F80_0000, 32'h3F00_0000, REGION_NEG_COS, OP_BOTH);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("direct_cos", out_cos, 32'hBF80_0000);
        check("direct_sin", out_sin, 32'h3F00_0000);
        send(32'h1234_5678, 32'hBF00_0000, REGION_NEG_SIN, OP_SIN);
        send(32'h1234_5678, 32'hBF00_0000, REGION_NONE2, OP_SIN);
        send(32'h0000_0000, 32'h4000_0000, REGION_NEG_COS, OP_COS);
        send(32'h8000_0000, 32'h0000_0000, REGION_NEG_SIN, OP_BOTH);
        drain();

        // Backpressure: two beats fill the FIFO, the third waits.
        set_out_ready(1'b0);
        send(32'h0000_0011, 32'h0000_0022, REGION_NONE, OP_BOTH);
        send(32'h0000_0033, 32'h0000_0044, REGION_NEG_COS, OP_BOTH);
        check("full_in_ready", 32'(in_ready), 32'd0);
        fork
            send(32'h0000_0055, 32'h0000_0066, REGION_NEG_SIN, OP_BOTH);
            begin
                repeat (3) @(posedge clk);
                #1 check("held_in_ready", 32'(in_ready), 32'd0);
                check("held_count", 32'(sbq.size()), 32'd2);
                out_ready = 1'b1;
            end
        join
        drain();

        // Push and pop together at occupancy 1.
        set_out_ready(1'b0);
        send(32'h0000_0100, 32'h0000_0200, REGION_NONE, OP_BOTH);
        set_out_ready(1'b1);
        for (int i = 0; i < 10; i++) begin
            send(32'h0000_1000 + 32'(i), 32'h8000_2000 + 32'(i), 2'(i), 2'(i % 3));
            check("steady_out_valid", 32'(out_valid), 32'd1);
            check("steady_in_ready", 32'(in_ready), 32'd1);
        end
        drain();

        // Sticky error, then reset with two entries buffered.
        set_out_ready(1'b0);
        send(32'hC000_0000, 32'h4000_0000, REGION_NEG_COS, OP_ILL);
        check("err_op_set", 32'(err_op), 32'd1);
        send(32'h0000_0777, 32'h0000_0888, REGION_NONE, OP_COS);
        repeat (3) @(negedge clk);
        check("err_op_sticky", 32'(err_op), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_op", 32'(err_op), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Random traffic with random backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] x, y;
                    x = $urandom;
                    y = $urandom;
                    if ($urandom_range(0, 7) == 0) x[30:0] = '0;
                    if ($urandom_range(0, 7) == 0) y[30:0] = '0;
                    send(x, y, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
